// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - instruction/data memory handshake bundle for cpu_sequencer
interface cpu_sequencer_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ack,
        output dmem_ack
    );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb control FSM owning the pc
// Define CPU_SEQ_STEP_EN for single-step operation: WB returns to IDLE and waits for start.
module cpu_sequencer #(
    parameter int PC_W     = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    cpu_sequencer_if.master     mem,
    output logic                ir_load,
    input  logic                flag_hlt,
    input  logic                a_en,
    input  logic                m_en,
    input  logic                r_en_r,
    input  logic                r_en_w,
    input  logic                j_en,
    input  logic                mem_rw,
    input  logic                jmp_taken,
    input  logic [PC_W-1:0]     jmp_target,
    output logic                alu_en,
    output logic                reg_rd_en,
    output logic                reg_we,
    output logic [PC_W-1:0]     pc,
    output logic                halted,
    output logic                bus_err,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam int              CNT_W     = $clog2(WAIT_MAX + 1);
    // Last no-ack cycle before giving up; an ack in this same cycle still wins.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

    state_t           st;
    logic [CNT_W-1:0] wait_cnt;
    logic             hlt_q;
    logic             a_en_q;
    logic             m_en_q;
    logic             r_en_r_q;
    logic             r_en_w_q;
    logic             j_en_q;
    logic             mem_rw_q;

    assign state        = st;
    assign mem.imem_req = (st == S_FETCH);
    assign ir_load      = (st == S_FETCH) && mem.imem_ack;
    assign alu_en       = (st == S_EXEC) && a_en_q;
    assign reg_rd_en    = (st == S_EXEC) && r_en_r_q;
    assign mem.dmem_req = (st == S_MEM);
    assign mem.dmem_we  = (st == S_MEM) && mem_rw_q;
    assign reg_we       = (st == S_WB) && r_en_w_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= S_IDLE;
            pc       <= '0;
            halted   <= 1'b0;
            bus_err  <= 1'b0;
            wait_cnt <= '0;
            hlt_q    <= 1'b0;
            a_en_q   <= 1'b0;
            m_en_q   <= 1'b0;
            r_en_r_q <= 1'b0;
            r_en_w_q <= 1'b0;
            j_en_q   <= 1'b0;
            mem_rw_q <= 1'b0;
        end else begin
            case (st)
                S_IDLE: begin
                    wait_cnt <= '0;
                    if (start) begin
                        st <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (mem.imem_ack) begin
                        wait_cnt <= '0;
                        st       <= S_DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        bus_err  <= 1'b1;
                        halted   <= 1'b1;
                        st       <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    hlt_q    <= flag_hlt;
                    a_en_q   <= a_en;
                    m_en_q   <= m_en;
                    r_en_r_q <= r_en_r;
                    r_en_w_q <= r_en_w;
                    j_en_q   <= j_en;
                    mem_rw_q <= mem_rw;
                    if (flag_hlt) begin
                        halted <= 1'b1;
                        st     <= S_HALT;
                    end else begin
                        st <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // A latched halt never reaches the datapath strobes.
                    if (hlt_q) begin
                        halted <= 1'b1;
                        st     <= S_HALT;
                    end else if (m_en_q) begin
                        st <= S_MEM;
                    end else begin
                        st <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem.dmem_ack) begin
                        wait_cnt <= '0;
                        st       <= S_WB;
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        bus_err  <= 1'b1;
                        halted   <= 1'b1;
                        st       <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    if (j_en_q && jmp_taken) begin
                        pc <= jmp_target;
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
`ifdef CPU_SEQ_STEP_EN
                    st <= S_IDLE;
`else
                    st <= S_FETCH;
`endif
                end
                S_HALT: begin
                    wait_cnt <= '0;
                end
                default: begin
                    wait_cnt <= '0;
                    st       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
